gerenciador_de_ataque_n: RTL
============================

GERENCIADOR_DE_ATAQUE_N -- requirements
Module: gerenciador_de_ataque_n

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, as listed below.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- COLS, 5, number of grid columns
- ROWS, 7, number of grid rows
- MAX_TIROS, 20, shot budget per game
- CW, 3, coordinate width (COLS and ROWS each ≤ 2^CW)
- SW, 6, shot and hit counter width
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock
- reset, in, 1, synchronous active-high reset
- enable, in, 1, game active; low clears the game
- confirmar, in, 1, fire request (level input; internally edge-detected)
- coordColuna, in, CW, column of the shot
- coordLinha, in, CW, row of the shot
- mapa, in, COLS*ROWS, ship map; bit index col*ROWS+row
- matriz, out, COLS*ROWS, revealed hits; same indexing as mapa
- LED_R / LED_G / LED_B, out, 1 each, status of the last shot
- tiros, out, SW, valid shots fired
- acertos, out, SW, distinct hits
- vitoria, out, 1, all ship cells hit
- derrota, out, 1, shot budget exhausted without win

Function
REQ-004 States SHALL be: OCIOSO, JOGANDO, VITORIA, DERROTA.
REQ-005 From OCIOSO, enable=1 SHALL move to JOGANDO on the next edge; enable=0 in any state SHALL clear matriz, tiros, acertos and LEDs and go to OCIOSO on the next edge.
REQ-006 The block SHALL register confirmar into confirmar_q; a shot event is confirmar=1 and confirmar_q=0 at a clock edge in JOGANDO.
REQ-007 A held confirmar SHALL fire exactly once.
REQ-008 A shot SHALL update all outputs at that same edge, giving 1-cycle latency from the sampled edge to visible outputs.
REQ-009 A shot with coordColuna≥COLS or coordLinha≥ROWS is invalid: LED=R1G0B1, no counter change, matriz unchanged.
REQ-010 A valid shot on a cell already set in matriz is a repeat: LED=R0G0B1, tiros unchanged, acertos unchanged.
REQ-011 A valid new shot on a mapa=1 cell is a hit: set the matriz bit, LED=R0G1B0, tiros+1, acertos+1.
REQ-012 A valid new shot on a mapa=0 cell is a miss: LED=R1G0B0, tiros+1. The matriz bit SHALL stay 0, so a repeated miss is also a miss and is counted again.
REQ-013 The block SHALL transition to VITORIA when the post-shot acertos equals popcount(mapa) and popcount(mapa)>0.
REQ-014 Otherwise the block SHALL transition to DERROTA when the post-shot tiros equals MAX_TIROS.
REQ-015 If the win and loss conditions occur on the same shot, VITORIA SHALL take priority.
REQ-016 vitoria and derrota SHALL be high exactly while in their respective state.
REQ-017 In VITORIA and DERROTA, shot events SHALL be ignored and the LEDs SHALL hold the value of the last shot.
REQ-018 Counters SHALL saturate at 2^SW−1 and never wrap.
REQ-019 mapa SHALL be stable during JOGANDO; a mapa change mid-game gives undefined win detection only and SHALL NOT cause lockup.
REQ-020 confirmar with enable=0 SHALL have no effect.

Reset
REQ-021 reset=1 at a clock edge SHALL set: state=OCIOSO, matriz=0, tiros=0, acertos=0, LED_R/G/B=0, confirmar_q=1.
REQ-022 Setting confirmar_q=1 at reset SHALL ensure that a confirmar held high through reset does not fire.
REQ-023 reset SHALL dominate enable and confirmar.
REQ-024 Reset mid-game SHALL discard all progress.

Structure
REQ-025 A shared package gerenciador_pkg SHALL hold the state encoding, the LED code constants (MISS, HIT, REPEAT, INVALID) and the default grid dimensions.
REQ-026 The popcount of mapa SHALL be a sub-module contador_de_bits, parametrised by width N and purely combinational.
REQ-027 The cell index SHALL be computed as col*ROWS+row, gated by range checks before any indexing.

Verification
REQ-028 The bench SHALL cover these scenarios (default parameters; mapa bits 0, 1 and 8 set, target total 3):
- Reset, enable=1, shot at (0,0) → matriz bit0=1, LED=G, tiros=1, acertos=1 on the edge after sampling.
- Shot (0,0) again → LED=B, tiros=1, acertos=1.
- confirmar held high for 5 cycles at (2,3) → exactly one miss: LED=R, tiros=2.
- Shot at (5,0) and at (0,7) → LED=R+B each, counters unchanged.
- Hits (0,1) then (1,1) → acertos=3, vitoria=1. A further shot is ignored.
- MAX_TIROS=4 with 4 misses → derrota=1 after the 4th. Then enable=0 for one cycle → everything cleared, state OCIOSO. Reset asserted with confirmar high, then released → no shot fires.

Source files
------------

// File: rtl/gerenciador_pkg.sv
// Shared definitions for the battleship attack manager: state encoding,
// LED status codes ({R,G,B}) and default grid dimensions.
package gerenciador_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    JOGANDO = 2'd1,
    VITORIA = 2'd2,
    DERROTA = 2'd3
  } estado_t;

  // LED codes packed as {R, G, B}
  localparam logic [2:0] LED_OFF     = 3'b000;
  localparam logic [2:0] LED_MISS    = 3'b100;
  localparam logic [2:0] LED_HIT     = 3'b010;
  localparam logic [2:0] LED_REPEAT  = 3'b001;
  localparam logic [2:0] LED_INVALID = 3'b101;

  localparam int COLS_DEF = 5;
  localparam int ROWS_DEF = 7;

endpackage

// File: rtl/contador_de_bits.sv
// Combinational population count of an N-bit vector.
module contador_de_bits #(
  parameter int N  = 35,
  parameter int OW = $clog2(N + 1)
) (
  input  logic [N-1:0]  bits_i,
  output logic [OW-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < N; i++) begin
      count_o = count_o + OW'(bits_i[i]);
    end
  end

endmodule

// File: rtl/gerenciador_de_ataque_n.sv
// Attack manager: edge-detects fire requests, classifies each shot against
// the ship map, tracks revealed hits and counters, and decides win/loss.
module gerenciador_de_ataque_n
  import gerenciador_pkg::*;
#(
  parameter int COLS      = COLS_DEF,
  parameter int ROWS      = ROWS_DEF,
  parameter int MAX_TIROS = 20,
  parameter int CW        = 3,
  parameter int SW        = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 confirmar,
  input  logic [CW-1:0]        coordColuna,
  input  logic [CW-1:0]        coordLinha,
  input  logic [COLS*ROWS-1:0] mapa,
  output logic [COLS*ROWS-1:0] matriz,
  output logic                 LED_R,
  output logic                 LED_G,
  output logic                 LED_B,
  output logic [SW-1:0]        tiros,
  output logic [SW-1:0]        acertos,
  output logic                 vitoria,
  output logic                 derrota,
  output estado_t              estado_o
);

  localparam int NC = COLS * ROWS;
  localparam int IW = (NC > 1) ? $clog2(NC) : 1;
  localparam int PW = $clog2(NC + 1);
  localparam logic [CW:0] COLS_LIM = (CW + 1)'(COLS);
  localparam logic [CW:0] ROWS_LIM = (CW + 1)'(ROWS);

  estado_t        estado_q, estado_d;
  logic [NC-1:0]  matriz_q, matriz_d;
  logic [SW-1:0]  tiros_q, tiros_d;
  logic [SW-1:0]  acertos_q, acertos_d;
  logic [2:0]     led_q, led_d;
  logic           confirmar_q;

  logic           disparo;
  logic           no_alcance;
  logic [IW-1:0]  idx;
  logic [PW-1:0]  total_navios;

  contador_de_bits #(.N(NC), .OW(PW)) u_popcount (
    .bits_i  (mapa),
    .count_o (total_navios)
  );

  assign disparo    = (estado_q == JOGANDO) && confirmar && !confirmar_q;
  assign no_alcance = ({1'b0, coordColuna} < COLS_LIM) && ({1'b0, coordLinha} < ROWS_LIM);

  // Index is only formed once the coordinates are known to be on the grid.
  always_comb begin
    idx = '0;
    if (no_alcance) begin
      idx = IW'(32'(coordColuna) * ROWS + 32'(coordLinha));
    end
  end

  always_comb begin
    estado_d  = estado_q;
    matriz_d  = matriz_q;
    tiros_d   = tiros_q;
    acertos_d = acertos_q;
    led_d     = led_q;
    if (!enable) begin
      estado_d  = OCIOSO;
      matriz_d  = '0;
      tiros_d   = '0;
      acertos_d = '0;
      led_d     = LED_OFF;
    end else begin
      case (estado_q)
        OCIOSO:  estado_d = JOGANDO;
        JOGANDO: begin
          if (disparo) begin
            if (!no_alcance) begin
              led_d = LED_INVALID;
            end else if (matriz_q[idx]) begin
              led_d = LED_REPEAT;
            end else if (mapa[idx]) begin
              matriz_d[idx] = 1'b1;
              led_d         = LED_HIT;
              tiros_d       = (tiros_q == '1) ? tiros_q : tiros_q + 1'b1;
              acertos_d     = (acertos_q == '1) ? acertos_q : acertos_q + 1'b1;
            end else begin
              led_d   = LED_MISS;
              tiros_d = (tiros_q == '1) ? tiros_q : tiros_q + 1'b1;
            end
            // Win is checked first so a final hit on the last allowed shot wins.
            if ((total_navios != '0) && (32'(acertos_d) == 32'(total_navios))) begin
              estado_d = VITORIA;
            end else if (32'(tiros_d) == 32'(MAX_TIROS)) begin
              estado_d = DERROTA;
            end
          end
        end
        default: estado_d = estado_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      matriz_q    <= '0;
      tiros_q     <= '0;
      acertos_q   <= '0;
      led_q       <= LED_OFF;
      confirmar_q <= 1'b1;
    end else begin
      estado_q    <= estado_d;
      matriz_q    <= matriz_d;
      tiros_q     <= tiros_d;
      acertos_q   <= acertos_d;
      led_q       <= led_d;
      confirmar_q <= confirmar;
    end
  end

  assign matriz   = matriz_q;
  assign tiros    = tiros_q;
  assign acertos  = acertos_q;
  assign LED_R    = led_q[2];
  assign LED_G    = led_q[1];
  assign LED_B    = led_q[0];
  assign vitoria  = (estado_q == VITORIA);
  assign derrota  = (estado_q == DERROTA);
  assign estado_o = estado_q;

endmodule
